// File: rtl/process_supervisor_if.sv
// Pin-side bundle of the run supervisor: start/completion requests in,
// core control and board status indicators out.
interface process_supervisor_if #(
  parameter int CNT_W = 14
);
  logic             start_process;
  logic             core_end;
  logic             core_reset;
  logic             core_enable;
  logic [CNT_W-1:0] cycle_count;
  logic             g1;
  logic             g2;
  logic             g3;

  modport master (
    input  start_process, core_end,
    output core_reset, core_enable, cycle_count, g1, g2, g3
  );

  modport slave (
    output start_process, core_end,
    input  core_reset, core_enable, cycle_count, g1, g2, g3
  );
endinterface

// File: rtl/process_supervisor.sv
// Run controller for the matrix core: qualifies the external start request,
// sequences core reset/enable, times the run and flags completion or timeout.
module process_supervisor #(
  parameter int STABLE_CYCLES  = 4,
  parameter int TIMEOUT_CYCLES = 8000,
  parameter int CNT_W          = 14
) (
  input  logic                 fast_clock,
  input  logic                 reset,
  process_supervisor_if.master bus
);

  localparam int ARM_W = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES + 1);
  localparam logic [ARM_W-1:0] ARM_LAST = ARM_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0] RUN_TMO  = CNT_W'(TIMEOUT_CYCLES);

  typedef enum logic [2:0] {IDLE, ARM, CLEAR, RUN, DONE, FAULT} state_t;

  state_t           state_q, state_d;
  logic [ARM_W-1:0] arm_q, arm_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             g2_q, g2_d;
  logic             g3_q, g3_d;
  logic             start_p0, start_p1;
  logic             start_s;

  // Count to report after one more RUN cycle without completion.
  function automatic logic [CNT_W-1:0] run_count_step(input logic [CNT_W-1:0] cnt);
    return (cnt == RUN_LAST) ? RUN_TMO : cnt + CNT_W'(1);
  endfunction

  // Stage p0/p1: two-flop synchronizer for the asynchronous start level
  always_ff @(posedge fast_clock or posedge reset) begin
    if (reset) begin
      start_p0 <= 1'b0;
      start_p1 <= 1'b0;
    end else begin
      start_p0 <= bus.start_process;
      start_p1 <= start_p0;
    end
  end

  assign start_s = start_p1;

  // Control state and run bookkeeping
  always_ff @(posedge fast_clock or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      arm_q   <= '0;
      cnt_q   <= '0;
      g2_q    <= 1'b0;
      g3_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      arm_q   <= arm_d;
      cnt_q   <= cnt_d;
      g2_q    <= g2_d;
      g3_q    <= g3_d;
    end
  end

  always_comb begin
    state_d = state_q;
    arm_d   = arm_q;
    cnt_d   = cnt_q;
    g2_d    = g2_q;
    g3_d    = g3_q;
    unique case (state_q)
      IDLE: begin
        if (start_s) begin
          arm_d   = ARM_W'(1);
          state_d = (STABLE_CYCLES == 1) ? CLEAR : ARM;
        end
      end
      ARM: begin
        if (!start_s) begin
          state_d = IDLE;
        end else if (arm_q == ARM_LAST) begin
          state_d = CLEAR;
        end else begin
          arm_d = arm_q + ARM_W'(1);
        end
      end
      CLEAR: begin
        cnt_d   = '0;
        g2_d    = 1'b0;
        g3_d    = 1'b0;
        state_d = RUN;
      end
      RUN: begin
        // Completion outranks a timeout landing on the same edge.
        if (bus.core_end) begin
          g2_d    = 1'b1;
          state_d = DONE;
        end else begin
          cnt_d = run_count_step(cnt_q);
          if (cnt_q == RUN_LAST) begin
            g3_d    = 1'b1;
            state_d = FAULT;
          end
        end
      end
      DONE, FAULT: begin
        // A relaunch needs the request to drop first.
        if (!start_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign bus.core_reset  = reset | (state_q == CLEAR);
  assign bus.core_enable = (state_q == RUN);
  assign bus.g1          = (state_q == RUN);
  assign bus.cycle_count = cnt_q;
  assign bus.g2          = g2_q;
  assign bus.g3          = g3_q;

endmodule

// File: tb/tb_process_supervisor.sv
// Directed bench for process_supervisor: launch latency, glitch rejection,
// completion, timeout, simultaneous end/timeout, relaunch and mid-run reset.
module tb_process_supervisor;

  localparam int CNT_W = 14;

  logic fast_clock;
  logic reset;
  int   errs;
  int   checks;
  int   en_cycles;
  int   guard;
  logic saw_rst;
  logic saw_en;

  process_supervisor_if #(.CNT_W(CNT_W)) sup_if ();

  process_supervisor #(
    .STABLE_CYCLES (4),
    .TIMEOUT_CYCLES(8000),
    .CNT_W         (CNT_W)
  ) dut (
    .fast_clock(fast_clock),
    .reset     (reset),
    .bus       (sup_if)
  );

  initial fast_clock = 1'b0;
  always #5 fast_clock = ~fast_clock;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errs++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge fast_clock);
    #1;
  endtask

  // Drive edges E0..E6 with start held high, checking the launch sequence.
  task automatic launch(input string tag);
    for (int i = 0; i <= 6; i++) begin
      tick();
      chk({tag, "_core_reset"}, sup_if.core_reset, (i == 5));
      chk({tag, "_core_enable"}, sup_if.core_enable, (i >= 6));
    end
    chk({tag, "_g1"}, sup_if.g1, 1);
    chk({tag, "_cnt0"}, sup_if.cycle_count, 0);
  endtask

  initial begin
    errs = 0;
    checks = 0;
    reset = 1'b1;
    sup_if.start_process = 1'b0;
    sup_if.core_end = 1'b0;
    #1;
    chk("rst_core_reset", sup_if.core_reset, 1);
    chk("rst_core_enable", sup_if.core_enable, 0);
    chk("rst_g1", sup_if.g1, 0);
    chk("rst_g2", sup_if.g2, 0);
    chk("rst_g3", sup_if.g3, 0);
    chk("rst_cnt", sup_if.cycle_count, 0);
    tick();
    tick();
    reset = 1'b0;
    #1;
    chk("rel_core_reset", sup_if.core_reset, 0);
    tick();

    // Launch at default latency, then complete at cycle_count == 100
    sup_if.start_process = 1'b1;
    launch("l1");
    chk("l1_g2", sup_if.g2, 0);
    chk("l1_g3", sup_if.g3, 0);
    en_cycles = 1;
    for (int k = 1; k <= 100; k++) begin
      tick();
      if (sup_if.core_enable) en_cycles++;
    end
    chk("run_cnt100", sup_if.cycle_count, 100);
    sup_if.core_end = 1'b1;
    tick();
    sup_if.core_end = 1'b0;
    chk("done_g2", sup_if.g2, 1);
    chk("done_g1", sup_if.g1, 0);
    chk("done_g3", sup_if.g3, 0);
    chk("done_cnt", sup_if.cycle_count, 100);
    chk("done_enable", sup_if.core_enable, 0);
    chk("done_en_cycles", en_cycles, 101);

    // Held request after DONE must not relaunch
    saw_en = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (sup_if.core_enable) saw_en = 1'b1;
    end
    chk("hold_no_relaunch", saw_en, 0);
    chk("hold_g2", sup_if.g2, 1);
    sup_if.start_process = 1'b0;
    repeat (4) tick();

    // Glitch: three synchronized high samples, then low
    sup_if.start_process = 1'b1;
    tick();
    tick();
    tick();
    sup_if.start_process = 1'b0;
    saw_rst = 1'b0;
    saw_en = 1'b0;
    for (int k = 0; k < 12; k++) begin
      tick();
      if (sup_if.core_reset) saw_rst = 1'b1;
      if (sup_if.core_enable) saw_en = 1'b1;
    end
    chk("glitch_core_reset", saw_rst, 0);
    chk("glitch_core_enable", saw_en, 0);
    chk("glitch_g2_sticky", sup_if.g2, 1);
    chk("glitch_cnt_sticky", sup_if.cycle_count, 100);

    // Timeout: core_end never asserted
    sup_if.start_process = 1'b1;
    launch("l2");
    chk("l2_g2_cleared", sup_if.g2, 0);
    en_cycles = 1;
    guard = 0;
    while (sup_if.core_enable && guard < 9000) begin
      tick();
      guard++;
      if (sup_if.core_enable) en_cycles++;
    end
    chk("tmo_bound", (guard < 9000), 1);
    chk("tmo_en_cycles", en_cycles, 8000);
    chk("tmo_g3", sup_if.g3, 1);
    chk("tmo_g2", sup_if.g2, 0);
    chk("tmo_cnt", sup_if.cycle_count, 8000);
    chk("tmo_g1", sup_if.g1, 0);
    sup_if.start_process = 1'b0;
    repeat (4) tick();
    chk("idle_g3_sticky", sup_if.g3, 1);

    // core_end coincides with the timeout cycle
    sup_if.start_process = 1'b1;
    launch("l3");
    chk("l3_g3_cleared", sup_if.g3, 0);
    repeat (7999) tick();
    chk("sim_cnt7999", sup_if.cycle_count, 7999);
    sup_if.core_end = 1'b1;
    tick();
    sup_if.core_end = 1'b0;
    chk("sim_g2", sup_if.g2, 1);
    chk("sim_g3", sup_if.g3, 0);
    chk("sim_cnt", sup_if.cycle_count, 7999);
    saw_en = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (sup_if.core_enable) saw_en = 1'b1;
    end
    chk("sim_no_relaunch", saw_en, 0);
    sup_if.start_process = 1'b0;
    repeat (4) tick();

    // Relaunch after deassertion, then reset at cycle_count == 50
    sup_if.start_process = 1'b1;
    launch("l4");
    chk("l4_g2_cleared", sup_if.g2, 0);
    repeat (50) tick();
    chk("mid_cnt50", sup_if.cycle_count, 50);
    #1 reset = 1'b1;
    #1;
    chk("mid_core_enable", sup_if.core_enable, 0);
    chk("mid_g1", sup_if.g1, 0);
    chk("mid_core_reset", sup_if.core_reset, 1);
    chk("mid_cnt", sup_if.cycle_count, 0);
    chk("mid_g2", sup_if.g2, 0);
    #1 reset = 1'b0;
    #1;
    chk("mid_rel_core_reset", sup_if.core_reset, 0);
    launch("l5");

    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end

endmodule

// File: doc/process_supervisor.md
# process_supervisor

Run controller at the processor's start/stop boundary: it receives the external `start_process` request, qualifies and synchronizes it, and sequences the matrix-multiplication core through reset, enable and completion. It measures the run in clock cycles, aborts on timeout, and drives the three board status indicators `g1`/`g2`/`g3`. It sits inside `top_processor` between the top-level pins and the core's enable and reset inputs.

## Interface
- `STABLE_CYCLES`, 4: consecutive synchronized high samples of `start_process` needed to launch a run (≥1).
- `TIMEOUT_CYCLES`, 8000: maximum RUN length in cycles before fault (1..2^CNT_W−1).
- `CNT_W`, 14: width of the cycle counter.
- `fast_clock`  in  1  sole clock; all state changes on its rising edge.
- `reset`  in  1  asynchronous, active-high reset.
- `start_process`  in  1  run request, level, asynchronous to `fast_clock`.
- `core_end`  in  1  core reports completion; sampled only in RUN.
- `core_reset`  out  1  core reset = `reset` OR (state==CLEAR).
- `core_enable`  out  1  high only in RUN.
- `cycle_count`  out  CNT_W  cycles spent in RUN in the current or last run.
- `g1`  out  1  running (state==RUN).
- `g2`  out  1  sticky: last run completed.
- `g3`  out  1  sticky: last run timed out.

## Operation
- Two-flop synchronizer on `start_process` gives `start_s`; the FSM uses `start_s` only.
- States: IDLE, ARM, CLEAR, RUN, DONE, FAULT.
- IDLE: if `start_s` → ARM, with the arm counter set to 1.
- ARM: if `start_s` is low → IDLE. Otherwise the arm counter increments. On the sample that makes STABLE_CYCLES consecutive highs → CLEAR. With STABLE_CYCLES=1, IDLE goes directly to CLEAR.
- CLEAR (exactly 1 cycle): `core_reset`=1, `cycle_count`←0, `g2`←0, `g3`←0, → RUN.
- RUN: at each edge:
  - If `core_end`=1 → DONE, `g2`←1, `cycle_count` unchanged.
  - Else if `cycle_count`==TIMEOUT_CYCLES−1 → FAULT, `g3`←1, `cycle_count`←TIMEOUT_CYCLES.
  - Else `cycle_count`+1.
  - If `core_end` and timeout coincide, `core_end` wins (DONE).
- DONE / FAULT: hold while `start_s`=1. When `start_s`=0 → IDLE. A new run requires a deassertion followed by a fresh qualified assertion.
- `start_s` dropping during RUN has no effect; the run continues to completion or timeout.
- `core_end` outside RUN is ignored.
- `cycle_count`, `g2` and `g3` hold their values through DONE, FAULT and IDLE until the next CLEAR.
- `g1`, `core_enable` and `core_reset` are decoded from the registered state. No registered output depends combinationally on `start_process` or `core_end`.

## Timing
- Reset (async, immediate): state IDLE, synchronizer 0, arm counter 0, `cycle_count`=0, `g1`=`g2`=`g3`=0, `core_enable`=0, `core_reset`=1 while `reset` is high.
- Release of `reset` takes effect at the first following edge; `core_reset` falls with `reset`.
- Launch latency: `start_process` is first sampled high at edge E0 and held. Then:
  - `start_s`=1 after E1.
  - ARM from E2.
  - CLEAR from E(1+STABLE_CYCLES): E5 at defaults.
  - RUN and `core_enable`=1 from E(2+STABLE_CYCLES): E6.
- Run length: `core_enable` is high for N+1 cycles when `core_end` is high during the RUN cycle where `cycle_count`==N. The final `cycle_count`=N.
- Timeout: RUN lasts exactly TIMEOUT_CYCLES cycles; the final `cycle_count`=TIMEOUT_CYCLES.
- Reset mid-run: `core_enable` and `g1` drop and `core_reset` rises asynchronously. The sticky flags and `cycle_count` clear.

## Test plan
- Reset, then `start_process` high at E0 and held (defaults) → `core_reset`=1 only in the cycle after E5. `core_enable`/`g1` rise after E6. `g2`=`g3`=0.
- Start glitch: high for 3 synchronized samples, then low → FSM returns to IDLE. `core_reset` and `core_enable` are never asserted.
- Normal run: `core_end` pulsed while `cycle_count`==100 → DONE. `g2`=1, `g1`=0, `cycle_count`=100. `core_enable` was high for 101 cycles.
- Timeout: `core_end` never asserted → FAULT after 8000 RUN cycles. `g3`=1, `cycle_count`=8000, `core_enable`=0.
- Simultaneous events: `core_end`=1 while `cycle_count`==7999 → DONE (`g2`=1, `g3`=0, `cycle_count`=7999). Then `start_process` held high → no relaunch. Drop to low and reassert → new run; `g2` clears at CLEAR.
- Reset asserted mid-RUN at `cycle_count`=50 → outputs zero immediately and `core_reset`=1. After release, with `start_process` still high, a new run launches with latency equal to the launch latency.
